// File: rtl/reg_init_pkg.sv
// reg_init_pkg
//   Shared definitions for the register-initialisation master:
//   opcode constants, FSM state encoding and the bit offsets of the
//   fields inside a command word {op[1:0], addr, data}.
package reg_init_pkg;

   localparam logic [1:0] OP_END  = 2'b00;
   localparam logic [1:0] OP_WR   = 2'b01;
   localparam logic [1:0] OP_RDC  = 2'b10;
   localparam logic [1:0] OP_POLL = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_STROBE,
      ST_GAP,
      ST_DONE
   } state_t;

   // Command word layout, LSB first: data, then addr, then the 2-bit op.
   function automatic int cmd_data_lsb();
      return 0;
   endfunction

   function automatic int cmd_addr_lsb(input int data_w);
      return data_w;
   endfunction

   function automatic int cmd_op_lsb(input int addr_w, input int data_w);
      return addr_w + data_w;
   endfunction

endpackage

// File: rtl/reg_init_timer.sv
// reg_init_timer
//   Loadable down-counter shared by the STROBE and GAP phases.
//   Load with (cycles-1); 'last' is high during the final cycle of the
//   phase. The counter parks at zero when not reloaded.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   load, load_val reload request and value (takes effect next cycle)
//   last           counter is at zero
module reg_init_timer
#(
   parameter int CNT_W = 1
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             last
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign last = (cnt_q == '0);

endmodule

// File: rtl/reg_init_master.sv
// reg_init_master
//   CPU-bus master that walks a command table and drives the MAC host
//   register interface. Commands: END, WR, RDC (read-compare), POLL
//   (read until equal, bounded by POLL_MAX attempts).
// Ports:
//   Clk_reg, Reset          clock, asynchronous active-high reset
//   Start                   pulse, (re)starts the table at index 0
//   Cmd_addr / Cmd_data     table read port, data valid one cycle later
//   CSB, WRB, CA, CD_in     register bus outputs (all registered)
//   CD_out                  register read data
//   Busy, CPU_init_end      running / finished status
//   Err, Err_index          failure flag and index of failing command
//   Rd_data                 last sampled read value
module reg_init_master
   import reg_init_pkg::*;
#(
   parameter int ADDR_W     = 7,
   parameter int DATA_W     = 16,
   parameter int IDX_W      = 8,
   parameter int STROBE_CYC = 2,
   parameter int GAP_CYC    = 2,
   parameter int POLL_MAX   = 1023
)
(
   input  logic                       Clk_reg,
   input  logic                       Reset,
   input  logic                       Start,
   output logic [IDX_W-1:0]           Cmd_addr,
   input  logic [2+ADDR_W+DATA_W-1:0] Cmd_data,
   output logic                       CSB,
   output logic                       WRB,
   output logic [ADDR_W:0]            CA,
   output logic [DATA_W-1:0]          CD_in,
   input  logic [DATA_W-1:0]          CD_out,
   output logic                       Busy,
   output logic                       CPU_init_end,
   output logic                       Err,
   output logic [IDX_W-1:0]           Err_index,
   output logic [DATA_W-1:0]          Rd_data
);

   localparam int OP_LSB   = cmd_op_lsb(ADDR_W, DATA_W);
   localparam int ADDR_LSB = cmd_addr_lsb(DATA_W);
   localparam int DATA_LSB = cmd_data_lsb();
   localparam int T_MAX    = (STROBE_CYC > GAP_CYC) ? STROBE_CYC : GAP_CYC;
   localparam int CNT_W    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam int ATT_W    = $clog2(POLL_MAX + 1);

   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYC - 1);
   // att_q counts attempts already retried, so the attempt in flight is
   // att_q+1; another retry is allowed while that is below POLL_MAX.
   localparam logic [ATT_W-1:0] ATT_LAST  = ATT_W'(POLL_MAX - 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [1:0]          op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [ATT_W-1:0]    att_q, att_d;
   logic                csb_q, csb_d;
   logic                wrb_q, wrb_d;
   logic [ADDR_W:0]     ca_q, ca_d;
   logic [DATA_W-1:0]   cd_q, cd_d;
   logic                busy_q, busy_d;
   logic                end_q, end_d;
   logic                err_q, err_d;
   logic [IDX_W-1:0]    err_idx_q, err_idx_d;
   logic [DATA_W-1:0]   rd_q, rd_d;

   logic                tmr_load;
   logic [CNT_W-1:0]    tmr_val;
   logic                tmr_last;
   logic                advance;
   logic                fail;

   logic [1:0]          cmd_op;
   logic [ADDR_W-1:0]   cmd_addr_f;
   logic [DATA_W-1:0]   cmd_data_f;

   assign cmd_op     = Cmd_data[OP_LSB +: 2];
   assign cmd_addr_f = Cmd_data[ADDR_LSB +: ADDR_W];
   assign cmd_data_f = Cmd_data[DATA_LSB +: DATA_W];

   reg_init_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (Clk_reg),
      .rst      (Reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .last     (tmr_last)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      op_d      = op_q;
      addr_d    = addr_q;
      data_d    = data_q;
      att_d     = att_q;
      csb_d     = csb_q;
      wrb_d     = wrb_q;
      ca_d      = ca_q;
      cd_d      = cd_q;
      busy_d    = busy_q;
      end_d     = end_q;
      err_d     = err_q;
      err_idx_d = err_idx_q;
      rd_d      = rd_q;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      advance   = 1'b0;
      fail      = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (Start) begin
               idx_d   = '0;
               err_d   = 1'b0;
               end_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: state_d = ST_DECODE;
         ST_DECODE: begin
            op_d   = cmd_op;
            addr_d = cmd_addr_f;
            data_d = cmd_data_f;
            att_d  = '0;
            if (cmd_op == OP_END) begin
               busy_d  = 1'b0;
               end_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               csb_d    = 1'b0;
               ca_d     = {cmd_addr_f, 1'b0};
               wrb_d    = (cmd_op != OP_WR);
               cd_d     = (cmd_op == OP_WR) ? cmd_data_f : '0;
               tmr_load = 1'b1;
               tmr_val  = STROBE_LD;
               state_d  = ST_STROBE;
            end
         end
         ST_STROBE: begin
            if (tmr_last) begin
               if (op_q != OP_WR) rd_d = CD_out;
               csb_d    = 1'b1;
               wrb_d    = 1'b1;
               ca_d     = '0;
               cd_d     = '0;
               tmr_load = 1'b1;
               tmr_val  = GAP_LD;
               state_d  = ST_GAP;
            end
         end
         ST_GAP: begin
            if (tmr_last) begin
               case (op_q)
                  OP_WR:  advance = 1'b1;
                  OP_RDC: begin
                     if (rd_q != data_q) fail = 1'b1;
                     else                advance = 1'b1;
                  end
                  OP_POLL: begin
                     if (rd_q == data_q) advance = 1'b1;
                     else if (att_q < ATT_LAST) begin
                        // Retry the same command without refetching.
                        att_d    = att_q + 1'b1;
                        csb_d    = 1'b0;
                        ca_d     = {addr_q, 1'b0};
                        tmr_load = 1'b1;
                        tmr_val  = STROBE_LD;
                        state_d  = ST_STROBE;
                     end else
                        fail = 1'b1;
                  end
                  default: ;
               endcase

               if (fail) begin
                  err_d     = 1'b1;
                  err_idx_d = idx_q;
                  busy_d    = 1'b0;
                  end_d     = 1'b1;
                  state_d   = ST_DONE;
               end else if (advance) begin
                  // Last table slot acts as an implicit END; no wrap.
                  if (idx_q == '1) begin
                     busy_d  = 1'b0;
                     end_d   = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     state_d = ST_FETCH;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk_reg or posedge Reset) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         op_q      <= OP_END;
         addr_q    <= '0;
         data_q    <= '0;
         att_q     <= '0;
         csb_q     <= 1'b1;
         wrb_q     <= 1'b1;
         ca_q      <= '0;
         cd_q      <= '0;
         busy_q    <= 1'b0;
         end_q     <= 1'b0;
         err_q     <= 1'b0;
         err_idx_q <= '0;
         rd_q      <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         att_q     <= att_d;
         csb_q     <= csb_d;
         wrb_q     <= wrb_d;
         ca_q      <= ca_d;
         cd_q      <= cd_d;
         busy_q    <= busy_d;
         end_q     <= end_d;
         err_q     <= err_d;
         err_idx_q <= err_idx_d;
         rd_q      <= rd_d;
      end
   end

   assign Cmd_addr     = idx_q;
   assign CSB          = csb_q;
   assign WRB          = wrb_q;
   assign CA           = ca_q;
   assign CD_in        = cd_q;
   assign Busy         = busy_q;
   assign CPU_init_end = end_q;
   assign Err          = err_q;
   assign Err_index    = err_idx_q;
   assign Rd_data      = rd_q;

endmodule

// File: tb/tb_reg_init_master.sv
// Bench for reg_init_master. A command-level model walks the table and
// pushes the expected bus accesses, read responses and final status into
// queues; a negedge monitor pops and compares as the DUT presents them.
module tb_reg_init_master;

   localparam int AW = 7;
   localparam int DW = 16;
   localparam int IW = 8;
   localparam int S  = 2;
   localparam int G  = 2;
   localparam int PM = 4;

   typedef struct {
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            period;   // cycles since previous CSB fall, 0 = unchecked
   } acc_t;

   typedef struct {
      bit            err;
      logic [IW-1:0] idx;
      logic [DW-1:0] rd;
   } stat_t;

   logic                Clk_reg = 1'b0;
   logic                Reset;
   logic                Start;
   logic [IW-1:0]       Cmd_addr;
   logic [2+AW+DW-1:0]  Cmd_data = '0;
   logic                CSB, WRB;
   logic [AW:0]         CA;
   logic [DW-1:0]       CD_in;
   logic [DW-1:0]       CD_out = '0;
   logic                Busy, CPU_init_end, Err;
   logic [IW-1:0]       Err_index;
   logic [DW-1:0]       Rd_data;

   int checks = 0;
   int fails  = 0;

   logic [2+AW+DW-1:0]  rom  [256];
   int                  miss [256];   // mismatching reads before a match
   logic [DW-1:0]       mask [256];   // XOR applied to data for a mismatch
   logic [DW-1:0]       model_rd;

   acc_t          exp_q [$];
   logic [DW-1:0] rsp_q [$];
   stat_t         stat_q[$];

   reg_init_master #(
      .ADDR_W(AW), .DATA_W(DW), .IDX_W(IW),
      .STROBE_CYC(S), .GAP_CYC(G), .POLL_MAX(PM)
   ) dut (
      .Clk_reg(Clk_reg), .Reset(Reset), .Start(Start),
      .Cmd_addr(Cmd_addr), .Cmd_data(Cmd_data),
      .CSB(CSB), .WRB(WRB), .CA(CA), .CD_in(CD_in), .CD_out(CD_out),
      .Busy(Busy), .CPU_init_end(CPU_init_end), .Err(Err),
      .Err_index(Err_index), .Rd_data(Rd_data)
   );

   always #5 Clk_reg = ~Clk_reg;

   // Behavioural command ROM, one cycle read latency.
   always @(posedge Clk_reg) Cmd_data <= rom[Cmd_addr];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic set_cmd(input int i, input logic [1:0] op, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int m, input logic [DW-1:0] mk);
      rom[i]  = {op, a, d};
      miss[i] = m;
      mask[i] = mk;
   endtask

   // Reference: walk the table command by command, producing the bus
   // accesses, read responses, final status and total cycle count.
   task automatic build_expect(output int cyc);
      int            i, att;
      bit            first, err;
      logic [1:0]    op;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      acc_t          x;
      stat_t         s;
      i = 0; first = 1; err = 0; cyc = 0;
      forever begin
         {op, a, d} = rom[i];
         cyc += 2;                               // fetch + decode
         if (op == 2'b00) break;
         if (op == 2'b01) begin
            x.wr = 1; x.addr = a; x.data = d;
            x.period = first ? 0 : S + G + 2;
            exp_q.push_back(x);
            first = 0;
            cyc += S + G;
         end else begin
            att = (op == 2'b10) ? 1 : ((miss[i] < PM) ? miss[i] + 1 : PM);
            for (int k = 0; k < att; k++) begin
               x.wr = 0; x.addr = a; x.data = '0;
               x.period = first ? 0 : ((k == 0) ? S + G + 2 : S + G);
               exp_q.push_back(x);
               first = 0;
               model_rd = (k < miss[i]) ? (d ^ mask[i]) : d;
               rsp_q.push_back(model_rd);
            end
            cyc += att * (S + G);
            if (miss[i] >= att) begin err = 1; break; end
         end
         if (i == 255) break;
         i++;
      end
      s.err = err; s.idx = IW'(i); s.rd = model_rd;
      stat_q.push_back(s);
   endtask

   task automatic run_seq(input bit poke_start, input string nm);
      int exp_cyc, n;
      build_expect(exp_cyc);
      @(negedge Clk_reg); Start = 1'b1;
      @(posedge Clk_reg); #1; Start = 1'b0;
      n = 0;
      while (!CPU_init_end && n < exp_cyc + 50) begin
         @(posedge Clk_reg); #1;
         n++;
         Start = poke_start && (n == 5);   // must be ignored while busy
      end
      Start = 1'b0;
      chk({nm, "_cycles"}, 32'(n), 32'(exp_cyc));
      repeat (6) @(posedge Clk_reg);
      chk({nm, "_status_seen"}, 32'(stat_q.size()), 32'd0);
      chk({nm, "_accesses_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor / scoreboard
   bit   csb_prev = 1, end_prev = 0, cur_rd = 0;
   int   low_cnt = 0, cyc_cnt = 0, last_fall = 0;
   always @(negedge Clk_reg) begin
      acc_t  x;
      stat_t s;
      if (Reset) begin
         csb_prev = 1; end_prev = 0; low_cnt = 0; cur_rd = 0;
         CD_out = '0;
      end else begin
         cyc_cnt++;
         if (CSB) begin
            chk("idle_bus", {WRB, 7'd0, CA, CD_in}, {1'b1, 7'd0, 8'd0, 16'd0});
         end
         if (!CSB && csb_prev) begin
            if (exp_q.size() == 0) begin
               checks++; fails++;
               $display("FAIL unexpected_access ca=%0h wrb=%0b", CA, WRB);
            end else begin
               x = exp_q.pop_front();
               chk("acc_wrb", 32'(WRB), 32'(!x.wr));
               chk("acc_ca", 32'(CA), 32'({x.addr, 1'b0}));
               chk("acc_cd_in", 32'(CD_in), 32'(x.data));
               if (x.period != 0) chk("acc_period", 32'(cyc_cnt - last_fall), 32'(x.period));
            end
            last_fall = cyc_cnt;
            cur_rd = WRB;
            low_cnt = 1;
         end else if (!CSB) begin
            low_cnt++;
         end
         if (CSB && !csb_prev) begin
            chk("strobe_len", 32'(low_cnt), 32'(S));
            if (cur_rd && rsp_q.size() != 0) void'(rsp_q.pop_front());
         end
         if (CPU_init_end && !end_prev) begin
            if (stat_q.size() == 0) begin
               checks++; fails++;
               $display("FAIL unexpected_end err=%0b", Err);
            end else begin
               s = stat_q.pop_front();
               chk("end_busy", 32'(Busy), 32'd0);
               chk("end_err", 32'(Err), 32'(s.err));
               if (s.err) chk("end_err_index", 32'(Err_index), 32'(s.idx));
               chk("end_rd_data", 32'(Rd_data), 32'(s.rd));
               chk("end_missing_acc", 32'(exp_q.size()), 32'd0);
            end
         end
         CD_out   = (rsp_q.size() != 0) ? rsp_q[0] : '0;
         csb_prev = CSB;
         end_prev = CPU_init_end;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] a2;
      int            len;
      logic [1:0]    op;
      Reset = 1'b1; Start = 1'b0; model_rd = '0;
      for (int i = 0; i < 256; i++) set_cmd(i, 2'b00, '0, '0, 0, 16'h1);
      repeat (3) @(posedge Clk_reg); #1;
      chk("rst_csb", 32'(CSB), 32'd1);
      chk("rst_wrb", 32'(WRB), 32'd1);
      chk("rst_ca", 32'(CA), 32'd0);
      chk("rst_cd_in", 32'(CD_in), 32'd0);
      chk("rst_cmd_addr", 32'(Cmd_addr), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_end", 32'(CPU_init_end), 32'd0);
      chk("rst_err", 32'(Err), 32'd0);
      chk("rst_err_index", 32'(Err_index), 32'd0);
      chk("rst_rd_data", 32'(Rd_data), 32'd0);
      @(negedge Clk_reg); Reset = 1'b0;
      repeat (2) @(posedge Clk_reg);

      // Single write then END: 8 cycles to CPU_init_end.
      set_cmd(0, 2'b01, 7'h05, 16'h1234, 0, 16'h1);
      set_cmd(1, 2'b00, '0, '0, 0, 16'h1);
      run_seq(0, "wr1");

      // Read-compare match, then mismatch stopping before the next command.
      set_cmd(0, 2'b10, 7'h10, 16'hBEEF, 0, 16'h1);
      set_cmd(1, 2'b00, '0, '0, 0, 16'h1);
      run_seq(0, "rdc_ok");
      set_cmd(0, 2'b10, 7'h10, 16'hBEEF, 1, 16'h1);
      set_cmd(1, 2'b01, 7'h11, 16'h7777, 0, 16'h1);
      set_cmd(2, 2'b00, '0, '0, 0, 16'h1);
      run_seq(0, "rdc_bad");

      // Poll matching on the 4th attempt, sequence continues.
      set_cmd(0, 2'b11, 7'h20, 16'h0001, 3, 16'h1);
      set_cmd(1, 2'b01, 7'h21, 16'h5555, 0, 16'h1);
      set_cmd(2, 2'b00, '0, '0, 0, 16'h1);
      run_seq(0, "poll_ok");

      // Poll never matching: timeout after PM attempts at index 1.
      set_cmd(0, 2'b01, 7'h01, 16'hA5A5, 0, 16'h1);
      set_cmd(1, 2'b11, 7'h22, 16'h00F0, PM, 16'h0F0F);
      set_cmd(2, 2'b01, 7'h23, 16'h1111, 0, 16'h1);
      run_seq(0, "poll_tmo");

      // Full table of writes, no END: implicit end at the last index.
      for (int i = 0; i < 256; i++)
         set_cmd(i, 2'b01, AW'($urandom), DW'($urandom), 0, 16'h1);
      run_seq(0, "full");

      // Reset during the strobe of write #3, then replay with a stray Start.
      set_cmd(10, 2'b00, '0, '0, 0, 16'h1);
      a2 = rom[2][DW +: AW];
      begin
         int dummy;
         build_expect(dummy);
      end
      @(negedge Clk_reg); Start = 1'b1;
      @(posedge Clk_reg); #1; Start = 1'b0;
      repeat (14) @(posedge Clk_reg);
      #3;
      chk("pre_rst_csb", 32'(CSB), 32'd0);
      chk("pre_rst_wrb", 32'(WRB), 32'd0);
      chk("pre_rst_ca", 32'(CA), 32'({a2, 1'b0}));
      Reset = 1'b1;
      #1;
      chk("async_rst_csb", 32'(CSB), 32'd1);
      chk("async_rst_busy", 32'(Busy), 32'd0);
      chk("async_rst_ca", 32'(CA), 32'd0);
      chk("async_rst_wrb", 32'(WRB), 32'd1);
      exp_q.delete(); rsp_q.delete(); stat_q.delete();
      model_rd = '0;
      repeat (2) @(negedge Clk_reg);
      Reset = 1'b0;
      repeat (2) @(posedge Clk_reg);
      run_seq(1, "replay");

      // Randomised tables.
      for (int t = 0; t < 10; t++) begin
         len = $urandom_range(1, 12);
         for (int i = 0; i < len; i++) begin
            op = 2'($urandom_range(1, 3));
            set_cmd(i, op, AW'($urandom), DW'($urandom),
                    (op == 2'b10) ? int'($urandom_range(0, 4) == 0) :
                    (op == 2'b11) ? int'($urandom_range(0, PM)) : 0,
                    DW'($urandom_range(1, 65535)));
         end
         set_cmd(len, 2'b00, '0, '0, 0, 16'h1);
         run_seq(t[0], "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
